// File: rtl/intc_if.sv
// intc_if: interrupt request lines, CPU handshake and register bus for intc.
interface intc_if #(parameter int NSRC = 8);
    logic [NSRC-1:0] irq;
    logic hwint, int_ack, rd, wr;
    logic [1:0] addr;
    logic [31:0] data_in, data_out;
    modport master(output irq, int_ack, rd, wr, addr, data_in, input hwint, data_out);
    modport slave(input irq, int_ack, rd, wr, addr, data_in, output hwint, data_out);
endinterface

// File: rtl/intc.sv
// intc: edge-triggered, fixed-priority interrupt controller with
// memory-mapped PENDING/ENABLE/ACTIVE/EOI registers and a non-nesting handshake.
module intc #(parameter int NSRC = 8) (
    input logic clk,
    input logic rst,
    intc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t state_q, state_d;
    logic [NSRC-1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, edge_q, edge_d;
    logic [NSRC-1:0] pending_q, pending_d, enable_q, enable_d, pe, sel, clr;
    logic in_service_q, in_service_d, hwint_q, hwint_d, ack, wr_pend, wr_en, wr_eoi;
    logic [3:0] active_id_q, active_id_d, id;
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
            prev_q <= '0;
            edge_q <= '0;
            pending_q <= '0;
            enable_q <= '0;
            in_service_q <= 1'b0;
            active_id_q <= '0;
            hwint_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
            pending_q <= pending_d;
            enable_q <= enable_d;
            in_service_q <= in_service_d;
            active_id_q <= active_id_d;
            hwint_q <= hwint_d;
            state_q <= state_d;
        end
    end
    always_comb begin
        s1_d = bus.irq;
        s2_d = s1_q;
        prev_d = s2_q;
        edge_d = s2_q & ~prev_q;
        pe = pending_q & enable_q;
        id = '0;
        sel = '0;
        // Descending scan so the lowest set index is the one left standing.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pe[i]) begin
                id = 4'(i);
                sel = '0;
                sel[i] = 1'b1;
            end
        end
        wr_pend = bus.wr && bus.addr == 2'd0;
        wr_en = bus.wr && bus.addr == 2'd1;
        wr_eoi = bus.wr && bus.addr == 2'd3;
        ack = bus.int_ack && state_q == REQ && |pe;
        clr = (wr_pend ? bus.data_in[NSRC-1:0] : '0) | (ack ? sel : '0);
        // A fresh edge outranks any clear landing on the same bit.
        pending_d = (pending_q & ~clr) | edge_q;
        enable_d = wr_en ? bus.data_in[NSRC-1:0] : enable_q;
        in_service_d = ack | (in_service_q & ~wr_eoi);
        active_id_d = ack ? id : active_id_q;
        hwint_d = |pe & ~in_service_q;
        state_d = state_q == IDLE ? (|pe ? REQ : IDLE) :
                  state_q == REQ ? (ack ? SERVICE : |pe ? REQ : IDLE) :
                  wr_eoi ? IDLE : SERVICE;
    end
    assign bus.hwint = hwint_q;
    assign bus.data_out = (!rst || !bus.rd) ? '0 :
                          bus.addr == 2'd0 ? 32'(pending_q) :
                          bus.addr == 2'd1 ? 32'(enable_q) :
                          bus.addr == 2'd2 ? {in_service_q, 27'd0, active_id_q} : '0;
endmodule

// File: tb/tb_intc.sv
// tb_intc: directed scenarios plus randomized traffic checked against a
// behavioural model of the interrupt controller.
module tb_intc;
    localparam int NSRC = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] v;
    intc_if #(.NSRC(NSRC)) bus();
    intc #(.NSRC(NSRC)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // Model: an irq level sampled at edge M-3 that was low at M-4 lands in pending at M.
    logic [NSRC-1:0] m_samp [4];
    logic [NSRC-1:0] m_pend, m_en;
    logic m_ins, m_hw, m_req;
    logic [3:0] m_id;
    always @(posedge clk) begin : model
        logic [NSRC-1:0] pe, clr, set;
        int id;
        bit ack_ok;
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_samp[i] = '0;
            m_pend = '0; m_en = '0; m_ins = 0; m_hw = 0; m_req = 0; m_id = '0;
        end else begin
            pe = m_pend & m_en;
            id = -1;
            for (int i = 0; i < NSRC; i++) if (pe[i] && id < 0) id = i;
            ack_ok = bus.int_ack && m_req && id >= 0;
            set = m_samp[2] & ~m_samp[3];
            clr = (bus.wr && bus.addr == 2'd0) ? bus.data_in[NSRC-1:0] : '0;
            if (ack_ok) clr[id] = 1'b1;
            m_hw = (pe != 0) && !m_ins;
            m_req = (pe != 0) && !m_ins && !ack_ok;
            if (ack_ok) begin m_ins = 1; m_id = 4'(id); end
            else if (bus.wr && bus.addr == 2'd3) m_ins = 0;
            m_pend = (m_pend & ~clr) | set;
            if (bus.wr && bus.addr == 2'd1) m_en = bus.data_in[NSRC-1:0];
            for (int i = 3; i > 0; i--) m_samp[i] = m_samp[i-1];
            m_samp[0] = bus.irq;
        end
    end

    function automatic logic [31:0] exp_read();
        if (!rst || !bus.rd) return '0;
        case (bus.addr)
            2'd0: return 32'(m_pend);
            2'd1: return 32'(m_en);
            2'd2: return {m_ins, 27'd0, m_id};
            default: return '0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 0; bus.irq = '0; bus.int_ack = 0; bus.rd = 0; bus.wr = 0; bus.addr = 0; bus.data_in = 0;
        @(negedge clk);
        rst = 1;
    endtask
    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        bus.wr = 1; bus.addr = a; bus.data_in = d;
        @(negedge clk);
        bus.wr = 0; bus.data_in = 0;
    endtask
    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        bus.rd = 1; bus.addr = a;
        #1 d = bus.data_out;
        bus.rd = 0;
    endtask
    task automatic pulse(input logic [NSRC-1:0] m);
        bus.irq = bus.irq | m;
        @(negedge clk);
        bus.irq = bus.irq & ~m;
    endtask
    task automatic ack_pulse();
        bus.int_ack = 1;
        @(negedge clk);
        bus.int_ack = 0;
    endtask

    task automatic test_reset();
        bus.irq = '0; bus.int_ack = 0; bus.wr = 0; bus.data_in = 0;
        @(negedge clk);
        rst = 0; bus.irq = 8'h80; bus.rd = 1; bus.addr = 2'd1;
        #1 n_vec++; if (bus.data_out !== 32'h0) begin n_err++; $display("FAIL reset_dout: got %h want 0", bus.data_out); end
        bus.rd = 0;
        @(negedge clk);
        n_vec++; if (bus.hwint !== 1'b0) begin n_err++; $display("FAIL reset_hwint: got %b want 0", bus.hwint); end
        rst = 1;
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_pend: got %h want 0", v); end
        rd_reg(2'd1, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_en: got %h want 0", v); end
        rd_reg(2'd2, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_active: got %h want 0", v); end
        repeat (3) @(negedge clk);
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL held_high_early: got %h want 0", v); end
        @(negedge clk);
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h80) begin n_err++; $display("FAIL held_high_edge: got %h want 80", v); end
        bus.irq = '0;
    endtask

    task automatic test_basic();
        do_reset();
        wr_reg(2'd1, 32'h01);
        pulse(8'h01);
        repeat (2) @(negedge clk);
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL lat_pend_n2: got %h want 0", v); end
        @(negedge clk);
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL lat_pend_n3: got %h want 1", v); end
        n_vec++; if (bus.hwint !== 1'b0) begin n_err++; $display("FAIL lat_hw_n3: got %b want 0", bus.hwint); end
        @(negedge clk);
        n_vec++; if (bus.hwint !== 1'b1) begin n_err++; $display("FAIL lat_hw_n4: got %b want 1", bus.hwint); end
        ack_pulse();
        rd_reg(2'd2, v); n_vec++; if (v !== 32'h80000000) begin n_err++; $display("FAIL basic_active: got %h want 80000000", v); end
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL basic_pend: got %h want 0", v); end
        @(negedge clk);
        n_vec++; if (bus.hwint !== 1'b0) begin n_err++; $display("FAIL basic_hw_svc: got %b want 0", bus.hwint); end
    endtask

    task automatic test_priority();
        do_reset();
        wr_reg(2'd1, 32'hFF);
        pulse(8'h24);
        repeat (4) @(negedge clk);
        n_vec++; if (bus.hwint !== 1'b1) begin n_err++; $display("FAIL prio_hw: got %b want 1", bus.hwint); end
        ack_pulse();
        rd_reg(2'd2, v); n_vec++; if (v !== 32'h80000002) begin n_err++; $display("FAIL prio_first: got %h want 80000002", v); end
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h20) begin n_err++; $display("FAIL prio_pend: got %h want 20", v); end
        ack_pulse();
        rd_reg(2'd2, v); n_vec++; if (v !== 32'h80000002) begin n_err++; $display("FAIL svc_ack_active: got %h want 80000002", v); end
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h20) begin n_err++; $display("FAIL svc_ack_pend: got %h want 20", v); end
        rd_reg(2'd3, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL eoi_read: got %h want 0", v); end
        wr_reg(2'd3, 32'hDEAD);
        n_vec++; if (bus.hwint !== 1'b0) begin n_err++; $display("FAIL eoi_hw0: got %b want 0", bus.hwint); end
        @(negedge clk);
        n_vec++; if (bus.hwint !== 1'b1) begin n_err++; $display("FAIL eoi_hw1: got %b want 1", bus.hwint); end
        ack_pulse();
        rd_reg(2'd2, v); n_vec++; if (v !== 32'h80000005) begin n_err++; $display("FAIL prio_second: got %h want 80000005", v); end
    endtask

    task automatic test_masked();
        do_reset();
        pulse(8'h08);
        repeat (3) @(negedge clk);
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h08) begin n_err++; $display("FAIL mask_pend: got %h want 08", v); end
        @(negedge clk);
        n_vec++; if (bus.hwint !== 1'b0) begin n_err++; $display("FAIL mask_hw: got %b want 0", bus.hwint); end
        wr_reg(2'd1, 32'h08);
        n_vec++; if (bus.hwint !== 1'b0) begin n_err++; $display("FAIL unmask_hw0: got %b want 0", bus.hwint); end
        @(negedge clk);
        n_vec++; if (bus.hwint !== 1'b1) begin n_err++; $display("FAIL unmask_hw1: got %b want 1", bus.hwint); end
    endtask

    task automatic test_w1c_race();
        do_reset();
        pulse(8'h10);
        repeat (3) @(negedge clk);
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h10) begin n_err++; $display("FAIL race_pre: got %h want 10", v); end
        pulse(8'h10);
        repeat (2) @(negedge clk);
        wr_reg(2'd0, 32'h10);
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h10) begin n_err++; $display("FAIL race_setwins: got %h want 10", v); end
        wr_reg(2'd0, 32'h10);
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL w1c_clear: got %h want 0", v); end
    endtask

    task automatic test_reset_in_service();
        do_reset();
        wr_reg(2'd1, 32'h01);
        pulse(8'h01);
        repeat (4) @(negedge clk);
        ack_pulse();
        pulse(8'h02);
        repeat (3) @(negedge clk);
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h02) begin n_err++; $display("FAIL svc_pend: got %h want 02", v); end
        n_vec++; if (bus.hwint !== 1'b0) begin n_err++; $display("FAIL svc_hw: got %b want 0", bus.hwint); end
        rst = 0;
        @(negedge clk);
        rst = 1;
        n_vec++; if (bus.hwint !== 1'b0) begin n_err++; $display("FAIL svc_rst_hw: got %b want 0", bus.hwint); end
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL svc_rst_pend: got %h want 0", v); end
        rd_reg(2'd1, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL svc_rst_en: got %h want 0", v); end
        rd_reg(2'd2, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL svc_rst_active: got %h want 0", v); end
    endtask

    task automatic test_ack_idle();
        do_reset();
        pulse(8'h40);
        repeat (3) @(negedge clk);
        ack_pulse();
        rd_reg(2'd0, v); n_vec++; if (v !== 32'h40) begin n_err++; $display("FAIL idle_ack_pend: got %h want 40", v); end
        rd_reg(2'd2, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL idle_ack_active: got %h want 0", v); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            e = exp_read();
            n_vec++; if (bus.hwint !== m_hw) begin n_err++; $display("FAIL rand_hwint@%0d: got %b want %b", c, bus.hwint, m_hw); end
            n_vec++; if (bus.data_out !== e) begin n_err++; $display("FAIL rand_dout@%0d: got %h want %h", c, bus.data_out, e); end
            bus.irq = bus.irq ^ NSRC'($urandom & $urandom & $urandom);
            bus.wr = $urandom_range(0, 4) == 0;
            bus.rd = $urandom_range(0, 1) == 1;
            bus.addr = 2'($urandom_range(0, 3));
            bus.data_in = $urandom;
            bus.int_ack = (bus.hwint && $urandom_range(0, 2) == 0) || $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 299) != 0;
            @(negedge clk);
        end
        bus.wr = 0; bus.rd = 0; bus.int_ack = 0; rst = 1;
    endtask

    initial begin
        bus.irq = '0; bus.int_ack = 0; bus.rd = 0; bus.wr = 0; bus.addr = 0; bus.data_in = 0;
        test_reset();
        test_basic();
        test_priority();
        test_masked();
        test_w1c_race();
        test_reset_in_service();
        test_ack_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/intc.md
INTC -- requirements
Module: intc

Interface
REQ-001 The module SHALL provide the parameter NSRC, default 8, which sets the number of interrupt sources (1..16).
REQ-002 The module SHALL provide port clk, input, 1, the system clock; all state updates on its rising edge.
REQ-003 The module SHALL provide port rst, input, 1, the reset: synchronous, active-low.
REQ-004 The module SHALL provide port irq, input, NSRC, the asynchronous level interrupt requests from peripherals.
REQ-005 The module SHALL provide port hwint, output, 1, the interrupt request to the control unit.
REQ-006 The module SHALL provide port int_ack, input, 1, a one-cycle pulse from the control unit on entering its hardware-interrupt vector state.
REQ-007 The module SHALL provide port addr, input, 2, the register select.
REQ-008 The module SHALL provide port rd, input, 1, the register read strobe.
REQ-009 The module SHALL provide port wr, input, 1, the register write strobe.
REQ-010 The module SHALL provide port data_in, input, 32, the write data.
REQ-011 The module SHALL provide port data_out, output, 32, the read data, driven only while rd=1, otherwise 0.

Function
REQ-012 Each irq bit SHALL pass through a 2-flop synchroniser, followed by a rising-edge detector (current sync=1, previous sync=0).
REQ-013 A detected edge on source i SHALL set pending[i] one cycle after detection, regardless of enable[i].
REQ-014 The first-cycle latency SHALL be: an irq rise sampled at edge N sets pending at edge N+3.
REQ-015 The register map SHALL be: addr 0 PENDING (read; write-1-to-clear).
REQ-016 The register map SHALL be: addr 1 ENABLE (read/write, bits NSRC-1:0).
REQ-017 The register map SHALL be: addr 2 ACTIVE, read-only, with bit31 = in_service and bits 3:0 = active_id.
REQ-018 The register map SHALL be: addr 3 EOI, a write of any value clears in_service, and a read returns 0.
REQ-019 Unused upper bits SHALL read 0.
REQ-020 Writes SHALL take effect at the clock edge where wr=1.
REQ-021 When rd and wr are both 1 in the same cycle, data_out SHALL return the pre-write value.
REQ-022 hwint SHALL be registered and equal to |(pending & enable) & !in_service, one cycle after its terms change.
REQ-023 The state machine SHALL have three states: IDLE, REQ and SERVICE.
REQ-024 IDLE SHALL transition to REQ when (pending & enable) is nonzero.
REQ-025 In REQ, int_ack SHALL cause a transition to SERVICE.
REQ-026 On the int_ack edge, the module SHALL latch active_id as the lowest-index set bit of pending & enable, clear that pending bit, and set in_service.
REQ-027 If enable is cleared while in REQ, the state SHALL return to IDLE without an ack.
REQ-028 SERVICE SHALL transition to IDLE on an EOI write; a still-nonzero pending & enable then re-raises hwint one cycle later.
REQ-029 An int_ack received in IDLE or SERVICE SHALL be ignored, with no state change.
REQ-030 When an edge-set and a clear (W1C or ack) of the same pending bit occur in one cycle, set SHALL win and the bit SHALL remain 1.
REQ-031 A second edge on an already-pending source SHALL be absorbed, with no counting.
REQ-032 Priority SHALL be fixed: index 0 is the highest priority.
REQ-033 Nesting SHALL NOT occur, because hwint is held low throughout SERVICE.

Reset
REQ-034 When rst=0 at a clock edge, the module SHALL set pending=0, enable=0, in_service=0, active_id=0, the synchronisers and edge-detect history to 0, state=IDLE and hwint=0.
REQ-035 A reset in any state, including SERVICE mid-handler, SHALL abandon that state immediately.
REQ-036 A source held high across reset release SHALL be treated as a rising edge only if its synchronised value was 0 at the first post-reset cycle.
REQ-037 data_out SHALL be 0 during reset.

Verification
REQ-038 Bench scenario: ENABLE=0x01, pulse irq[0] -> pending=0x01 at edge +3 and hwint=1 at edge +4; int_ack -> ACTIVE=0x80000000, pending=0, hwint=0.
REQ-039 Bench scenario: ENABLE=0xFF, irq[5] and irq[2] rise together -> ack gives active_id=2; EOI write -> hwint re-asserts after 1 cycle; next ack gives active_id=5.
REQ-040 Bench scenario: ENABLE=0x00, pulse irq[3] -> PENDING=0x08 and hwint=0; write ENABLE=0x08 -> hwint=1 one cycle later.
REQ-041 Bench scenario: PENDING=0x10, W1C write 0x10 in the same cycle as a new irq[4] edge is detected -> PENDING stays 0x10.
REQ-042 Bench scenario: in SERVICE, pulse irq[1] -> pending[1]=1 and hwint=0; apply rst=0 for one cycle -> all registers 0, state IDLE, hwint=0.
REQ-043 Bench scenario: int_ack pulsed in IDLE -> no change to ACTIVE or PENDING.
